icg_enable_ctrl: RTL and testbench
==================================

# icg_enable_ctrl

Idle-detect enable controller that drives the E and TE pins of a negative-edge integrated clock gate (icgtn family). It runs on the free-running clock and watches a BUSY activity flag from the gated domain. After a programmable number of consecutive idle cycles it drops E, and on any wake source it restores E. A ready handshake tells the requester when the gated clock is running again. It sits directly upstream of the clock gate cell, one instance per gated domain.

## Interface
- CNT_W, 8, width of the idle counter and of IDLE_LIMIT.
- WAKE_CYCLES, 2, cycles with E=1 before READY reasserts after a wake. Legal range is 1 to 2^CNT_W-1.

- CLK  in  1  free-running clock; the same net feeds CLKN of the downstream gate.
- RN  in  1  asynchronous, active-low reset.
- BUSY  in  1  domain activity; 1 means work is pending or in progress.
- WAKE  in  1  external wake request, level-sensitive.
- FORCE_ON  in  1  1 keeps the clock running and inhibits gating.
- SCAN_EN  in  1  scan/test enable.
- IDLE_LIMIT  in  CNT_W  consecutive idle cycles before gating; 0 disables gating.
- E  out  1  functional enable to the gate; registered.
- TE  out  1  test enable to the gate; equals SCAN_EN, combinational.
- READY  out  1  1 means the gated clock is stable and the domain may issue work; registered.
- GATED  out  1  status, 1 while in state GATED; registered.

## Operation
- Definition: idle = !BUSY && !FORCE_ON, sampled on the rising edge of CLK.
- States: RUN, GATED, WAKEUP. Internal counter cnt is CNT_W bits.
- Reset (RN=0, asynchronous): state=RUN, cnt=0, E=1, READY=1, GATED=0. The clock is never gated out of reset.

RUN (E=1, READY=1, GATED=0):
- If !idle or IDLE_LIMIT==0: cnt<=0.
- Else if cnt >= IDLE_LIMIT-1: go to GATED with E<=0, GATED<=1, READY<=0, cnt<=0.
- Else: cnt<=cnt+1.
- The >= comparison covers IDLE_LIMIT being lowered mid-count: the next idle edge gates.
- cnt never exceeds IDLE_LIMIT-1, so it cannot overflow.

GATED (E=0, READY=0, GATED=1):
- If BUSY || WAKE || FORCE_ON: go to WAKEUP with E<=1, GATED<=0, cnt<=0.
- Otherwise hold.

WAKEUP (E=1, READY=0, GATED=0):
- If cnt == WAKE_CYCLES-1: go to RUN with READY<=1, cnt<=0.
- Else: cnt<=cnt+1.
- BUSY, WAKE and FORCE_ON are ignored in this state; there is no re-gating during wakeup.

Other rules:
- Simultaneous events: in RUN, a BUSY/FORCE_ON assertion on the same edge that would reach the limit wins, and no gating happens.
- IDLE_LIMIT changes take effect on the next edge.
- TE = SCAN_EN at all times and does not affect the FSM. The gate's output clock runs whenever TE=1, regardless of E.

Handshake:
- The requester may raise BUSY at any time.
- The requester must not issue work into the gated domain while READY=0.

## Timing
- E, READY and GATED change only after the rising edge of CLK, and are flop outputs (glitch-free).
- E must settle before the falling edge of CLK, which is where the downstream gate captures its enable. The budget from clk-to-q through the E route to the gate setup is half a CLK period.
- TE is combinational from SCAN_EN. It is static during functional mode.
- Gate latency: with IDLE_LIMIT=N≥1 and idle first sampled at edge k, E falls after edge k+N-1. That is N idle edges, including edge k.
- Wake latency: a wake source sampled at edge j raises E after edge j. READY rises after edge j+WAKE_CYCLES.
- Reset mid-operation: E=1 and READY=1 immediately on RN falling, with no dependence on CLK.

## Test plan
- Reset release, BUSY=1, IDLE_LIMIT=4 → E=1, READY=1, GATED=0. Hold 20 cycles with no change.
- BUSY falls, IDLE_LIMIT=4 → E falls after the 4th idle edge, READY=0, GATED=1. BUSY pulsed high for 1 cycle after 3 idle edges → cnt clears, and E falls only after 4 further idle edges.
- In GATED, WAKE pulse for 1 cycle, WAKE_CYCLES=2 → E=1 after that edge, READY=1 two edges later, GATED=0. BUSY=0 during wakeup → no re-gate.
- IDLE_LIMIT=0 with 100 idle cycles → E stays 1. IDLE_LIMIT lowered from 10 to 3 when cnt=5 → gates on the next idle edge.
- FORCE_ON=1 with BUSY=0 → never gates. FORCE_ON raised in GATED → wakeup sequence. Assertion on the same edge as the limit → no gating.
- SCAN_EN toggled in every state → TE follows combinationally and state is unaffected. RN asserted in GATED → E=1 and READY=1 before the next CLK edge.

Source files
------------

// File: rtl/icg_enable_ctrl.sv
// icg_enable_ctrl: idle-detect E/TE controller for a negative-edge integrated clock gate.
module icg_enable_ctrl #(
  parameter int CNT_W       = 8,
  parameter int WAKE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             busy_i,
  input  logic             wake_i,
  input  logic             force_on_i,
  input  logic             scan_en_i,
  input  logic [CNT_W-1:0] idle_limit_i,
  output logic             e_o,
  output logic             te_o,
  output logic             ready_o,
  output logic             gated_o
);
  typedef enum logic [1:0] {RUN, GATED, WAKEUP} state_t;
  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             e_q, e_d, ready_q, ready_d, gated_q, gated_d;
  logic             idle;
  assign idle = !busy_i && !force_on_i;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    e_d     = e_q;
    ready_d = ready_q;
    gated_d = gated_q;
    case (state_q)
      RUN: begin
        if (!idle || idle_limit_i == '0) cnt_d = '0;
        // >= so that lowering the limit mid-count gates on the next idle edge
        else if (cnt_q >= idle_limit_i - CNT_W'(1)) begin
          state_d = GATED;
          e_d     = 1'b0;
          ready_d = 1'b0;
          gated_d = 1'b1;
          cnt_d   = '0;
        end else cnt_d = cnt_q + CNT_W'(1);
      end
      GATED: begin
        if (busy_i || wake_i || force_on_i) begin
          state_d = WAKEUP;
          e_d     = 1'b1;
          gated_d = 1'b0;
          cnt_d   = '0;
        end
      end
      WAKEUP: begin
        if (cnt_q == WAKE_LAST) begin
          state_d = RUN;
          ready_d = 1'b1;
          cnt_d   = '0;
        end else cnt_d = cnt_q + CNT_W'(1);
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
        e_d     = 1'b1;
        ready_d = 1'b1;
        gated_d = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
      e_q     <= 1'b1;
      ready_q <= 1'b1;
      gated_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      e_q     <= e_d;
      ready_q <= ready_d;
      gated_q <= gated_d;
    end
  end
  assign e_o     = e_q;
  assign ready_o = ready_q;
  assign gated_o = gated_q;
  assign te_o    = scan_en_i;
endmodule

// File: tb/tb_icg_enable_ctrl.sv
// tb_icg_enable_ctrl: directed and randomized checks of icg_enable_ctrl against a cycle model.
module tb_icg_enable_ctrl;
  localparam int CNT_W = 8, WAKE_CYCLES = 2;
  logic clk = 0, rst_n = 0, busy_i = 1, wake_i = 0, force_on_i = 0, scan_en_i = 0;
  logic [CNT_W-1:0] idle_limit_i = 4;
  logic e_o, te_o, ready_o, gated_o;
  int tests = 0, fails = 0;
  bit m_gated;
  int m_wl, m_idle;

  icg_enable_ctrl #(.CNT_W(CNT_W), .WAKE_CYCLES(WAKE_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n), .busy_i(busy_i), .wake_i(wake_i), .force_on_i(force_on_i),
    .scan_en_i(scan_en_i), .idle_limit_i(idle_limit_i), .e_o(e_o), .te_o(te_o),
    .ready_o(ready_o), .gated_o(gated_o));

  always #5 clk = ~clk;

  // Model: gated flag, remaining wake cycles, and a count of consecutive idle edges.
  task automatic model_reset();
    m_gated = 0; m_wl = 0; m_idle = 0;
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) begin
      if (m_gated) begin
        if (busy_i || wake_i || force_on_i) begin m_gated = 0; m_wl = WAKE_CYCLES; end
      end else if (m_wl > 0) m_wl--;
      else if (!busy_i && !force_on_i && idle_limit_i != 0) begin
        m_idle++;
        if (m_idle >= int'(idle_limit_i)) begin m_gated = 1; m_idle = 0; end
      end else m_idle = 0;
    end
    #1;
  endtask

  function automatic logic [2:0] exp_v();
    return {!m_gated, !m_gated && m_wl == 0, m_gated};
  endfunction

  task automatic go_gated();
    int n = 0;
    busy_i = 0; force_on_i = 0; wake_i = 0; idle_limit_i = 4;
    while (!gated_o && n < 20) begin step(); n++; end
    tests++;
    if (!gated_o) begin fails++; $display("FAIL go_gated: gated=%b want 1 within 20 cycles", gated_o); end
  endtask

  task automatic go_run();
    int n = 0;
    busy_i = 1; wake_i = 0; force_on_i = 0;
    step();
    while (!ready_o && n < 20) begin step(); n++; end
    tests++;
    if ({e_o, ready_o, gated_o} !== 3'b110) begin
      fails++; $display("FAIL go_run: {e,ready,gated}=%b want 110", {e_o, ready_o, gated_o});
    end
  endtask

  task automatic test_reset();
    model_reset();
    busy_i = 1; idle_limit_i = 4;
    #12;
    tests++;
    if ({e_o, ready_o, gated_o} !== 3'b110) begin
      fails++; $display("FAIL reset_state: {e,ready,gated}=%b want 110", {e_o, ready_o, gated_o});
    end
    rst_n = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      tests++;
      if ({e_o, ready_o, gated_o} !== 3'b110 || exp_v() !== 3'b110) begin
        fails++; $display("FAIL reset_hold cyc %0d: got %b want 110", i, {e_o, ready_o, gated_o});
      end
    end
  endtask

  task automatic test_idle_gate();
    int n = 0;
    busy_i = 0; idle_limit_i = 4;
    while (!gated_o && n < 12) begin
      step(); n++;
      tests++;
      if ({e_o, ready_o, gated_o} !== exp_v()) begin
        fails++; $display("FAIL idle_gate cyc %0d: got %b want %b", n, {e_o, ready_o, gated_o}, exp_v());
      end
    end
    tests++;
    if (n != 4 || e_o !== 1'b0) begin
      fails++; $display("FAIL idle_gate_latency: gated after %0d edges e=%b want 4 edges e=0", n, e_o);
    end
  endtask

  task automatic test_busy_pulse();
    int n = 0;
    go_run();
    busy_i = 0;
    repeat (3) step();
    busy_i = 1; step();
    busy_i = 0;
    while (!gated_o && n < 12) begin
      step(); n++;
      tests++;
      if ({e_o, ready_o, gated_o} !== exp_v()) begin
        fails++; $display("FAIL busy_pulse cyc %0d: got %b want %b", n, {e_o, ready_o, gated_o}, exp_v());
      end
    end
    tests++;
    if (n != 4) begin fails++; $display("FAIL busy_pulse_restart: gated after %0d edges want 4", n); end
  endtask

  task automatic test_wake();
    logic [2:0] want [3] = '{3'b100, 3'b100, 3'b110};
    if (!gated_o) go_gated();
    busy_i = 0; wake_i = 1; step();
    wake_i = 0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      tests++;
      if ({e_o, ready_o, gated_o} !== want[i] || exp_v() !== want[i]) begin
        fails++; $display("FAIL wake seq %0d: got %b want %b", i, {e_o, ready_o, gated_o}, want[i]);
      end
    end
  endtask

  task automatic test_limit_zero();
    int bad = 0;
    go_run();
    busy_i = 0; idle_limit_i = 0;
    repeat (100) begin step(); if (e_o !== 1'b1 || gated_o !== 1'b0) bad++; end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL limit_zero: %0d gated cycles want 0", bad); end
  endtask

  task automatic test_limit_lower();
    busy_i = 1; idle_limit_i = 10; step();
    busy_i = 0;
    repeat (5) step();
    tests++;
    if (gated_o !== 1'b0) begin fails++; $display("FAIL limit_lower_pre: gated=%b want 0", gated_o); end
    idle_limit_i = 3; step();
    tests++;
    if ({e_o, ready_o, gated_o} !== 3'b001 || exp_v() !== 3'b001) begin
      fails++; $display("FAIL limit_lower: got %b want 001", {e_o, ready_o, gated_o});
    end
  endtask

  task automatic test_force_on();
    int bad = 0;
    go_run();
    idle_limit_i = 4; busy_i = 0; force_on_i = 1;
    repeat (50) begin step(); if (gated_o !== 1'b0 || e_o !== 1'b1) bad++; end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL force_hold: %0d gated cycles want 0", bad); end
    go_gated();
    force_on_i = 1; step();
    tests++;
    if ({e_o, ready_o, gated_o} !== 3'b100 || exp_v() !== 3'b100) begin
      fails++; $display("FAIL force_wake: got %b want 100", {e_o, ready_o, gated_o});
    end
    repeat (2) step();
    tests++;
    if ({e_o, ready_o, gated_o} !== 3'b110) begin
      fails++; $display("FAIL force_ready: got %b want 110", {e_o, ready_o, gated_o});
    end
    force_on_i = 0; busy_i = 1; step();
    busy_i = 0; repeat (3) step();
    busy_i = 1; step();
    tests++;
    if ({e_o, ready_o, gated_o} !== 3'b110 || exp_v() !== 3'b110) begin
      fails++; $display("FAIL simultaneous_busy: got %b want 110", {e_o, ready_o, gated_o});
    end
    busy_i = 0; repeat (3) step();
    tests++;
    if (gated_o !== 1'b0) begin fails++; $display("FAIL simultaneous_recount: gated=%b want 0", gated_o); end
    step();
    tests++;
    if (gated_o !== 1'b1) begin fails++; $display("FAIL simultaneous_gate: gated=%b want 1", gated_o); end
  endtask

  task automatic test_scan_en();
    for (int s = 0; s < 3; s++) begin
      if (s == 0) go_run();
      if (s == 1) go_gated();
      if (s == 2) begin busy_i = 1; step(); end
      for (int t = 0; t < 2; t++) begin
        #2 scan_en_i = ~scan_en_i;
        #1;
        tests++;
        if (te_o !== scan_en_i || {e_o, ready_o, gated_o} !== exp_v()) begin
          fails++; $display("FAIL scan_en st %0d: te=%b want %b state %b want %b",
                            s, te_o, scan_en_i, {e_o, ready_o, gated_o}, exp_v());
        end
      end
      step();
    end
    scan_en_i = 0;
  endtask

  task automatic test_async_reset();
    go_gated();
    #2 rst_n = 0;
    #1;
    model_reset();
    tests++;
    if ({e_o, ready_o, gated_o} !== 3'b110) begin
      fails++; $display("FAIL async_reset: got %b want 110 before edge", {e_o, ready_o, gated_o});
    end
    busy_i = 1;
    step();
    rst_n = 1;
    step();
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 600; i++) begin
      busy_i     = ($urandom_range(0, 9) < 3);
      wake_i     = ($urandom_range(0, 19) == 0);
      force_on_i = ($urandom_range(0, 29) == 0);
      scan_en_i  = $urandom_range(0, 1);
      if ($urandom_range(0, 24) == 0) idle_limit_i = CNT_W'($urandom_range(0, 6));
      step();
      tests++;
      if ({e_o, ready_o, gated_o} !== exp_v() || te_o !== scan_en_i) begin
        fails++; bad++;
        if (bad < 10) $display("FAIL random cyc %0d: got %b te %b want %b te %b",
                               i, {e_o, ready_o, gated_o}, te_o, exp_v(), scan_en_i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_gate();
    test_busy_pulse();
    test_wake();
    test_limit_zero();
    test_limit_lower();
    test_force_on();
    test_scan_en();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
